// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter in front of the single-port SPI command RAM.
// An address command locks the grant to its issuer until the matching data
// command arrives. Read data is routed back to the lock owner. Every wait is
// bounded by a timeout so that a stalled requester or RAM cannot hang the bus.
module spi_ram_arbiter #(
   parameter int LOCK_TIMEOUT = 16,  // idle cycles tolerated in LOCKED
   parameter int RD_TIMEOUT   = 8    // cycles tolerated in WAIT_RD
) (
   input  logic       clk,
   input  logic       rst_n,
   // requester 0
   input  logic [9:0] req0_cmd,
   input  logic       req0_valid,
   output logic       req0_ready,
   output logic       req0_rsp_valid,
   output logic [7:0] req0_rsp_data,
   output logic       req0_rsp_err,
   // requester 1
   input  logic [9:0] req1_cmd,
   input  logic       req1_valid,
   output logic       req1_ready,
   output logic       req1_rsp_valid,
   output logic [7:0] req1_rsp_data,
   output logic       req1_rsp_err,
   // RAM side
   output logic [9:0] ram_din,
   output logic       ram_rx_valid,
   input  logic [7:0] ram_dout,
   input  logic       ram_tx_valid,
   // status
   output logic       busy,
   output logic       owner
);

   localparam int CNT_MAX = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] RD_LAST   = CW'(RD_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

   // Opcode bit 0 separates address (0) from data (1) commands;
   // bit 1 separates write (0) from read (1).
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          prio_q, prio_d;    // requester favoured on the next contention
   logic          owner_q, owner_d;
   logic          kind_q, kind_d;    // lock kind: 0 = write pair, 1 = read pair
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    ram_din_q, ram_din_d;
   logic          ram_rx_valid_q, ram_rx_valid_d;
   logic [1:0]    rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;

   // Per-requester views so the arbitration logic can be indexed by id.
   logic [9:0] req_cmd      [2];
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] rsp_data_arr [2];
   logic [1:0] rsp_err_arr;

   logic [1:0] acc_vec;
   logic       accept;
   logic       acc_id;
   logic [9:0] acc_cmd;
   logic [1:0] acc_op;

   assign req_cmd[0]   = req0_cmd;
   assign req_cmd[1]   = req1_cmd;
   assign req_valid[0] = req0_valid;
   assign req_valid[1] = req1_valid;

   // Counter that stops at its maximum instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + CW'(1);
   endfunction

   // Ready: arbitration in IDLE, owner-only in LOCKED, nobody in WAIT_RD.
   always_comb begin
      req_ready = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (req_valid[0] && (!req_valid[1] || !prio_q)) begin
               req_ready[0] = 1'b1;
            end else if (req_valid[1]) begin
               req_ready[1] = 1'b1;
            end
         end
         ST_LOCKED: req_ready[owner_q] = 1'b1;
         default:   req_ready = 2'b00;
      endcase
   end

   // At most one handshake per cycle because ready is one-hot or zero.
   assign acc_vec = req_valid & req_ready;
   assign accept  = |acc_vec;
   assign acc_id  = acc_vec[1];
   assign acc_cmd = acc_id ? req_cmd[1] : req_cmd[0];
   assign acc_op  = acc_cmd[9:8];

   // Next-state, forwarding and response generation.
   always_comb begin
      state_d        = state_q;
      prio_d         = prio_q;
      owner_d        = owner_q;
      kind_d         = kind_q;
      cnt_d          = cnt_q;
      ram_din_d      = ram_din_q;
      ram_rx_valid_d = 1'b0;
      rsp_valid_d    = 2'b00;
      rsp_data_d     = 8'h00;
      rsp_err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               prio_d = ~acc_id;
               if (!acc_op[0]) begin
                  // Address command opens a locked pair.
                  ram_din_d      = acc_cmd;
                  ram_rx_valid_d = 1'b1;
                  owner_d        = acc_id;
                  kind_d         = acc_op[1];
                  cnt_d          = '0;
                  state_d        = ST_LOCKED;
               end else begin
                  // Data command without a preceding address: swallow it.
                  rsp_valid_d[acc_id] = 1'b1;
                  rsp_err_d           = 1'b1;
               end
            end
         end

         ST_LOCKED: begin
            if (accept) begin
               cnt_d = '0;
               if (!acc_op[0]) begin
                  // Re-address: forward and adopt the new pair kind.
                  ram_din_d      = acc_cmd;
                  ram_rx_valid_d = 1'b1;
                  kind_d         = acc_op[1];
               end else if (acc_op == OP_WR_DATA && !kind_q) begin
                  ram_din_d      = acc_cmd;
                  ram_rx_valid_d = 1'b1;
                  state_d        = ST_IDLE;
               end else if (acc_op == OP_RD_DATA && kind_q) begin
                  ram_din_d      = acc_cmd;
                  ram_rx_valid_d = 1'b1;
                  state_d        = ST_WAIT_RD;
               end else begin
                  // Data op that does not match the open pair.
                  rsp_valid_d[acc_id] = 1'b1;
                  rsp_err_d           = 1'b1;
               end
            end else if (cnt_q >= LOCK_LAST) begin
               // Owner went quiet: drop the lock silently.
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         ST_WAIT_RD: begin
            if (ram_tx_valid) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_data_d           = ram_dout;
               cnt_d                = '0;
               state_d              = ST_IDLE;
            end else if (cnt_q >= RD_LAST) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
               cnt_d                = '0;
               state_d              = ST_IDLE;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         prio_q         <= 1'b0;
         owner_q        <= 1'b0;
         kind_q         <= 1'b0;
         cnt_q          <= '0;
         ram_din_q      <= 10'h000;
         ram_rx_valid_q <= 1'b0;
         rsp_valid_q    <= 2'b00;
         rsp_data_q     <= 8'h00;
         rsp_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         prio_q         <= prio_d;
         owner_q        <= owner_d;
         kind_q         <= kind_d;
         cnt_q          <= cnt_d;
         ram_din_q      <= ram_din_d;
         ram_rx_valid_q <= ram_rx_valid_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_err_q      <= rsp_err_d;
      end
   end

   // Response payload is shared; each requester only sees it with its own pulse.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         assign rsp_data_arr[gi] = rsp_valid_q[gi] ? rsp_data_q : 8'h00;
         assign rsp_err_arr[gi]  = rsp_valid_q[gi] & rsp_err_q;
      end
   endgenerate

   assign req0_ready     = req_ready[0];
   assign req1_ready     = req_ready[1];
   assign req0_rsp_valid = rsp_valid_q[0];
   assign req1_rsp_valid = rsp_valid_q[1];
   assign req0_rsp_data  = rsp_data_arr[0];
   assign req1_rsp_data  = rsp_data_arr[1];
   assign req0_rsp_err   = rsp_err_arr[0];
   assign req1_rsp_err   = rsp_err_arr[1];

   assign ram_din      = ram_din_q;
   assign ram_rx_valid = ram_rx_valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign owner        = owner_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for the timeouts and reset during a read.
module tb_spi_ram_arbiter;

   localparam int LT = 16;
   localparam int RT = 8;

   logic       clk;
   logic       rst_n;
   logic [9:0] req0_cmd, req1_cmd;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic       req0_rsp_valid, req1_rsp_valid;
   logic [7:0] req0_rsp_data, req1_rsp_data;
   logic       req0_rsp_err, req1_rsp_err;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;
   logic       busy;
   logic       owner;

   int tests = 0;
   int fails = 0;

   spi_ram_arbiter #(.LOCK_TIMEOUT(LT), .RD_TIMEOUT(RT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0_cmd       (req0_cmd),
      .req0_valid     (req0_valid),
      .req0_ready     (req0_ready),
      .req0_rsp_valid (req0_rsp_valid),
      .req0_rsp_data  (req0_rsp_data),
      .req0_rsp_err   (req0_rsp_err),
      .req1_cmd       (req1_cmd),
      .req1_valid     (req1_valid),
      .req1_ready     (req1_ready),
      .req1_rsp_valid (req1_rsp_valid),
      .req1_rsp_data  (req1_rsp_data),
      .req1_rsp_err   (req1_rsp_err),
      .ram_din        (ram_din),
      .ram_rx_valid   (ram_rx_valid),
      .ram_dout       (ram_dout),
      .ram_tx_valid   (ram_tx_valid),
      .busy           (busy),
      .owner          (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [9:0] c0;  logic v0;
      logic [9:0] c1;  logic v1;
      logic       tx;  logic [7:0] dout;
      logic [1:0] rdy;                 // {req1_ready, req0_ready} before the edge
      logic       rxv; logic [9:0] din;
      logic       rv0; logic [7:0] rd0; logic re0;
      logic       rv1; logic [7:0] rd1; logic re1;
      logic       bsy; logic own;
   } vec_t;

   vec_t vecs [26];

   function automatic vec_t mk(
      input logic [9:0] c0, input logic v0, input logic [9:0] c1, input logic v1,
      input logic tx, input logic [7:0] dout, input logic [1:0] rdy,
      input logic rxv, input logic [9:0] din,
      input logic rv0, input logic [7:0] rd0, input logic re0,
      input logic rv1, input logic [7:0] rd1, input logic re1,
      input logic bsy, input logic own);
      vec_t v;
      v.c0 = c0; v.v0 = v0; v.c1 = c1; v.v1 = v1; v.tx = tx; v.dout = dout;
      v.rdy = rdy; v.rxv = rxv; v.din = din;
      v.rv0 = rv0; v.rd0 = rd0; v.re0 = re0;
      v.rv1 = rv1; v.rd1 = rd1; v.re1 = re1;
      v.bsy = bsy; v.own = own;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] c0, input logic v0, input logic [9:0] c1,
                        input logic v1, input logic tx, input logic [7:0] dout);
      req0_cmd = c0; req0_valid = v0;
      req1_cmd = c1; req1_valid = v1;
      ram_tx_valid = tx; ram_dout = dout;
   endtask

   function automatic logic [32:0] outs_now();
      return {ram_rx_valid, ram_din, req0_rsp_valid, req0_rsp_data, req0_rsp_err,
              req1_rsp_valid, req1_rsp_data, req1_rsp_err, busy, owner};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'(outs_now()), 64'h0);
      check("reset_ready", 64'({req1_ready, req0_ready}), 64'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [32:0] exp_out;
      int          acc_k;
      int          bad;

      // Main-function vectors, one clock cycle each.
      vecs[0]  = mk(10'h0A5,1, 10'h000,0, 0,8'h00, 2'b01, 1,10'h0A5, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[1]  = mk(10'h13C,1, 10'h000,0, 0,8'h00, 2'b01, 1,10'h13C, 0,8'h00,0, 0,8'h00,0, 0,0);
      vecs[2]  = mk(10'h000,0, 10'h000,0, 0,8'h00, 2'b00, 0,10'h13C, 0,8'h00,0, 0,8'h00,0, 0,0);
      vecs[3]  = mk(10'h000,0, 10'h210,1, 0,8'h00, 2'b10, 1,10'h210, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[4]  = mk(10'h011,1, 10'h300,1, 0,8'h00, 2'b10, 1,10'h300, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[5]  = mk(10'h011,1, 10'h000,0, 0,8'h00, 2'b00, 0,10'h300, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[6]  = mk(10'h000,0, 10'h000,0, 1,8'h5A, 2'b00, 0,10'h300, 0,8'h00,0, 1,8'h5A,0, 0,1);
      vecs[7]  = mk(10'h000,0, 10'h000,0, 1,8'h77, 2'b00, 0,10'h300, 0,8'h00,0, 0,8'h00,0, 0,1);
      vecs[8]  = mk(10'h001,1, 10'h002,1, 0,8'h00, 2'b01, 1,10'h001, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[9]  = mk(10'h1AA,1, 10'h002,1, 0,8'h00, 2'b01, 1,10'h1AA, 0,8'h00,0, 0,8'h00,0, 0,0);
      vecs[10] = mk(10'h000,0, 10'h002,1, 0,8'h00, 2'b10, 1,10'h002, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[11] = mk(10'h000,0, 10'h1BB,1, 0,8'h00, 2'b10, 1,10'h1BB, 0,8'h00,0, 0,8'h00,0, 0,1);
      vecs[12] = mk(10'h003,1, 10'h004,1, 0,8'h00, 2'b01, 1,10'h003, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[13] = mk(10'h1CC,1, 10'h004,1, 0,8'h00, 2'b01, 1,10'h1CC, 0,8'h00,0, 0,8'h00,0, 0,0);
      vecs[14] = mk(10'h000,0, 10'h004,1, 0,8'h00, 2'b10, 1,10'h004, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[15] = mk(10'h000,0, 10'h1DD,1, 0,8'h00, 2'b10, 1,10'h1DD, 0,8'h00,0, 0,8'h00,0, 0,1);
      vecs[16] = mk(10'h0E0,1, 10'h000,0, 0,8'h00, 2'b01, 1,10'h0E0, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[17] = mk(10'h3FF,1, 10'h000,0, 0,8'h00, 2'b01, 0,10'h0E0, 1,8'h00,1, 0,8'h00,0, 1,0);
      vecs[18] = mk(10'h2E1,1, 10'h000,0, 0,8'h00, 2'b01, 1,10'h2E1, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[19] = mk(10'h1FF,1, 10'h000,0, 0,8'h00, 2'b01, 0,10'h2E1, 1,8'h00,1, 0,8'h00,0, 1,0);
      vecs[20] = mk(10'h3E2,1, 10'h000,0, 0,8'h00, 2'b01, 1,10'h3E2, 0,8'h00,0, 0,8'h00,0, 1,0);
      vecs[21] = mk(10'h000,0, 10'h000,0, 1,8'hC3, 2'b00, 0,10'h3E2, 1,8'hC3,0, 0,8'h00,0, 0,0);
      vecs[22] = mk(10'h000,0, 10'h0F0,1, 0,8'h00, 2'b10, 1,10'h0F0, 0,8'h00,0, 0,8'h00,0, 1,1);
      vecs[23] = mk(10'h000,0, 10'h1F1,1, 0,8'h00, 2'b10, 1,10'h1F1, 0,8'h00,0, 0,8'h00,0, 0,1);
      vecs[24] = mk(10'h000,0, 10'h3AB,1, 0,8'h00, 2'b10, 0,10'h1F1, 0,8'h00,0, 1,8'h00,1, 0,1);
      vecs[25] = mk(10'h000,0, 10'h000,0, 0,8'h00, 2'b00, 0,10'h1F1, 0,8'h00,0, 0,8'h00,0, 0,1);

      rst_n = 1'b0;
      drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
      #3;
      check("async_reset_outputs", 64'(outs_now()), 64'h0);
      do_reset();

      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].c0, vecs[i].v0, vecs[i].c1, vecs[i].v1, vecs[i].tx, vecs[i].dout);
         #1;
         check($sformatf("vec%0d_ready", i), 64'({req1_ready, req0_ready}), 64'(vecs[i].rdy));
         step();
         exp_out = {vecs[i].rxv, vecs[i].din, vecs[i].rv0, vecs[i].rd0, vecs[i].re0,
                    vecs[i].rv1, vecs[i].rd1, vecs[i].re1, vecs[i].bsy, vecs[i].own};
         check($sformatf("vec%0d_out", i), 64'(outs_now()), 64'(exp_out));
         $display("[TB] vec %0d: ready=%b rx=%b din=%h rsp0=%b/%h/%b rsp1=%b/%h/%b busy=%b owner=%b",
                  i, {req1_ready, req0_ready}, ram_rx_valid, ram_din,
                  req0_rsp_valid, req0_rsp_data, req0_rsp_err,
                  req1_rsp_valid, req1_rsp_data, req1_rsp_err, busy, owner);
      end

      // Read timeout: RAM never answers.
      do_reset();
      drive(10'h210, 1'b1, 10'h000, 1'b0, 1'b0, 8'h00);
      step();
      drive(10'h3FF, 1'b1, 10'h000, 1'b0, 1'b0, 8'h00);
      step();
      drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
      for (int k = 1; k <= RT; k++) begin
         step();
         if (k < RT) begin
            check($sformatf("rd_wait_%0d", k),
                  64'({req0_rsp_valid, req1_rsp_valid, busy}), 64'b001);
         end else begin
            check("rd_timeout_rsp",
                  64'({req0_rsp_valid, req0_rsp_err, req0_rsp_data, req1_rsp_valid, busy}),
                  64'({1'b1, 1'b1, 8'h00, 1'b0, 1'b0}));
         end
      end
      $display("[TB] read timeout: rsp0 err=%b data=%h busy=%b", req0_rsp_err, req0_rsp_data, busy);
      drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 8'hAB);
      step();
      check("stray_tx_ignored", 64'({req0_rsp_valid, req1_rsp_valid, busy}), 64'b000);
      $display("[TB] stray ram_tx_valid after timeout: rsp0=%b rsp1=%b", req0_rsp_valid, req1_rsp_valid);
      ram_tx_valid = 1'b0;

      // Lock timeout: req0 opens a pair and goes quiet, req1 waits.
      do_reset();
      drive(10'h010, 1'b1, 10'h000, 1'b0, 1'b0, 8'h00);
      step();
      drive(10'h000, 1'b0, 10'h020, 1'b1, 1'b0, 8'h00);
      acc_k = 0;
      bad   = 0;
      for (int k = 1; k <= 40 && acc_k == 0; k++) begin
         if (req1_ready !== ((k == LT + 1) ? 1'b1 : 1'b0)) bad++;
         step();
         if (ram_rx_valid === 1'b1) acc_k = k;
      end
      check("lock_ready_pattern", 64'(bad), 64'd0);
      check("lock_release_cycle", 64'(acc_k), 64'(LT + 1));
      check("lock_next_grant", 64'({ram_din, owner, busy}), 64'({10'h020, 1'b1, 1'b1}));
      $display("[TB] lock timeout: req1 accepted %0d cycles after req0 address, din=%h", acc_k, ram_din);
      req1_valid = 1'b0;

      // Reset asserted while waiting for read data.
      do_reset();
      drive(10'h000, 1'b0, 10'h2AA, 1'b1, 1'b0, 8'h00);
      step();
      drive(10'h000, 1'b0, 10'h3AA, 1'b1, 1'b0, 8'h00);
      step();
      drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
      step();
      check("wait_rd_busy", 64'({busy, owner}), 64'b11);
      ram_tx_valid = 1'b1;
      ram_dout     = 8'h99;
      #2;
      rst_n = 1'b0;
      #1;
      check("midop_reset_outputs", 64'(outs_now()), 64'h0);
      step();
      ram_tx_valid = 1'b0;
      rst_n        = 1'b1;
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if ({req0_rsp_valid, req1_rsp_valid, busy, ram_rx_valid} !== 4'b0000) bad++;
      end
      check("no_rsp_after_reset", 64'(bad), 64'd0);
      $display("[TB] reset during WAIT_RD: outputs=%h", outs_now());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
